// File: rtl/spi_ram.sv
// spi_ram: serial SRAM controller, one 48-bit SPI frame per access.
// Define SPI_RAM_INIT_EN to send WRMR (sequential mode) after reset.
module spi_ram #(
   parameter int CLOCK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        start,
   input  logic        write_enable,
   output logic        busy,
   output logic        ready,
   output logic        spi_cs,
   output logic        spi_clk,
   output logic        spi_do,
   input  logic        spi_di
);

`ifdef SPI_RAM_INIT_EN
   typedef enum logic [2:0] {
      IDLE, START, SHIFT, STOP, DONE, INIT
   } state_t;
   localparam state_t RESET_STATE = INIT;
   localparam logic [15:0] INIT_FRAME = 16'h0140;
`else
   typedef enum logic [2:0] {
      IDLE, START, SHIFT, STOP, DONE
   } state_t;
   localparam state_t RESET_STATE = IDLE;
`endif

   localparam logic [7:0] DIV_M1 = 8'(CLOCK_DIV - 1);
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ = 8'h03;

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [5:0]  bit_q, bit_d;
   logic [5:0]  last_bit;
   logic [47:0] shift_q, shift_d;
   logic [15:0] rx_q, rx_d;
   logic        wr_q, wr_d;
   logic [15:0] dout_d;
   logic        cs_d, sclk_d, mosi_d;
   logic        busy_d, ready_d;
   logic        div_end;
`ifdef SPI_RAM_INIT_EN
   logic        init_q, init_d;
`endif

   assign div_end = (div_q == DIV_M1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RESET_STATE;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         rx_q     <= '0;
         wr_q     <= 1'b0;
         data_out <= '0;
         spi_cs   <= 1'b1;
         spi_clk  <= 1'b0;
         spi_do   <= 1'b0;
         busy     <= 1'b0;
         ready    <= 1'b0;
`ifdef SPI_RAM_INIT_EN
         init_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         rx_q     <= rx_d;
         wr_q     <= wr_d;
         data_out <= dout_d;
         spi_cs   <= cs_d;
         spi_clk  <= sclk_d;
         spi_do   <= mosi_d;
         busy     <= busy_d;
         ready    <= ready_d;
`ifdef SPI_RAM_INIT_EN
         init_q   <= init_d;
`endif
      end
   end

   // All outputs are registered from the next-state values below.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      wr_d    = wr_q;
      dout_d  = data_out;
      cs_d    = spi_cs;
      sclk_d  = spi_clk;
      mosi_d  = spi_do;
`ifdef SPI_RAM_INIT_EN
      init_d   = init_q;
      last_bit = init_q ? 6'd15 : 6'd47;
`else
      last_bit = 6'd47;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               wr_d    = write_enable;
               shift_d = {
                  write_enable ? CMD_WRITE : CMD_READ,
                  7'b0, address, 1'b0,
                  write_enable ? data_in : 16'h0000
               };
               div_d   = '0;
               cs_d    = 1'b0;
               sclk_d  = 1'b0;
               mosi_d  = shift_d[47];
               state_d = START;
`ifdef SPI_RAM_INIT_EN
               init_d  = 1'b0;
`endif
            end
         end

         START: begin
            mosi_d = shift_q[47];
            if (div_end) begin
               div_d   = '0;
               bit_d   = '0;
               state_d = SHIFT;
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         SHIFT: begin
            if (!div_end) begin
               div_d = div_q + 8'd1;
            end else if (!spi_clk) begin
               div_d  = '0;
               sclk_d = 1'b1;
               rx_d   = {rx_q[14:0], spi_di};
            end else begin
               div_d  = '0;
               sclk_d = 1'b0;
               if (bit_q == last_bit) begin
                  cs_d    = 1'b1;
                  mosi_d  = 1'b0;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 6'd1;
                  shift_d = {shift_q[46:0], 1'b0};
                  mosi_d  = shift_q[46];
               end
            end
         end

         STOP: begin
            if (div_end) begin
               div_d   = '0;
               state_d = DONE;
               if (!wr_q) dout_d = rx_q;
`ifdef SPI_RAM_INIT_EN
               // The mode-register frame never signals completion.
               if (init_q) begin
                  state_d = IDLE;
                  dout_d  = data_out;
               end
`endif
            end else begin
               div_d = div_q + 8'd1;
            end
         end

         DONE: state_d = IDLE;

`ifdef SPI_RAM_INIT_EN
         INIT: begin
            init_d  = 1'b1;
            shift_d = {INIT_FRAME, 32'h0};
            div_d   = '0;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = INIT_FRAME[15];
            state_d = START;
         end
`endif

         default: state_d = IDLE;
      endcase

      busy_d  = (state_d != IDLE);
      ready_d = (state_d == DONE);
   end

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: random accesses against a word-level SRAM reference model.
// A behavioural SPI SRAM slave answers the DUT's frames.
module tb_spi_ram;

`ifdef SPI_RAM_INIT_EN
   localparam int DIV = 1;
`else
   localparam int DIV = 2;
`endif
   localparam int LIMIT = 98 * DIV + 40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        start = 1'b0;
   logic        write_enable = 1'b0;
   logic        busy, ready;
   logic        spi_cs, spi_clk, spi_do;
   logic        spi_di = 1'b0;

   always #5 clk = ~clk;

   spi_ram #(.CLOCK_DIV(DIV)) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .data_in(data_in),
      .data_out(data_out),
      .start(start),
      .write_enable(write_enable),
      .busy(busy),
      .ready(ready),
      .spi_cs(spi_cs),
      .spi_clk(spi_clk),
      .spi_do(spi_do),
      .spi_di(spi_di)
   );

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag,
                        input logic [47:0] got,
                        input logic [47:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // SRAM contents: bytes never written hold a fixed address pattern.
   logic [7:0] sram [int];
   function automatic logic [7:0] fill(input int x);
      return 8'(x * 37 + 11);
   endfunction
   function automatic logic [7:0] sram_byte(input int ba);
      if (sram.exists(ba)) return sram[ba];
      return fill(ba);
   endfunction

   int          frame_n[$];
   logic [47:0] frame_bits[$];
   logic        prev_cs = 1'b1;
   logic        prev_clk = 1'b0;
   int          nbits = 0;
   logic [47:0] rxb = '0;
   logic [15:0] rd_word = '0;
   logic [7:0]  rd_cmd = '0;

   always @(spi_cs, spi_clk) begin
      if (prev_cs !== 1'b0 && spi_cs === 1'b0) begin
         nbits = 0;
         rxb = '0;
      end else if (prev_cs === 1'b0 && spi_cs === 1'b1) begin
         if (nbits > 0) begin
            frame_n.push_back(nbits);
            frame_bits.push_back(rxb);
         end
         if (nbits == 48 && rxb[47:40] == 8'h02) begin
            sram[int'(rxb[39:16])] = rxb[15:8];
            sram[int'(rxb[39:16]) + 1] = rxb[7:0];
         end
         spi_di = 1'b0;
      end
      if (spi_cs === 1'b0 && prev_clk === 1'b0
          && spi_clk === 1'b1) begin
         rxb = {rxb[46:0], spi_do};
         nbits++;
      end
      if (spi_cs === 1'b0 && prev_clk === 1'b1
          && spi_clk === 1'b0) begin
         if (nbits == 32) begin
            rd_cmd = rxb[31:24];
            rd_word = {sram_byte(int'(rxb[23:0])),
                       sram_byte(int'(rxb[23:0]) + 1)};
         end
         if (nbits >= 32 && nbits < 48 && rd_cmd == 8'h03)
            spi_di = rd_word[47 - nbits];
         else
            spi_di = 1'b0;
      end
      prev_cs = spi_cs;
      prev_clk = spi_clk;
   end

   // Word-level reference: expected contents and last read value.
   logic [15:0] model_mem [int];
   logic [15:0] last_rd = '0;

   function automatic logic [15:0] model_word(input logic [15:0] a);
      int ba;
      ba = int'(a) * 2;
      if (model_mem.exists(int'(a))) return model_mem[int'(a)];
      return {fill(ba), fill(ba + 1)};
   endfunction

   task automatic check_frame(input bit we,
                              input logic [15:0] a,
                              input logic [15:0] d);
      int n;
      logic [47:0] b;
      check("frame_cnt", 48'(frame_n.size()), 48'd1);
      if (frame_n.size() > 0) begin
         n = frame_n.pop_front();
         b = frame_bits.pop_front();
         check("frame_len", 48'(n), 48'd48);
         check("mosi_cmd", 48'(b[47:40]), we ? 48'h02 : 48'h03);
         check("mosi_addr", 48'(b[39:16]), 48'(int'(a) * 2));
         check("mosi_data", 48'(b[15:0]), we ? 48'(d) : 48'h0);
      end
      frame_n.delete();
      frame_bits.delete();
   endtask

`ifdef SPI_RAM_INIT_EN
   task automatic post_reset();
      int n;
      bit seen_ready;
      bit late_busy;
      logic [47:0] b;
      n = 0;
      seen_ready = 1'b0;
      late_busy = 1'b0;
      while (n < 34 * DIV + 20) begin
         if (n == 2) begin
            start = 1'b1;
            write_enable = 1'b1;
            address = 16'h0042;
            data_in = 16'h1111;
         end
         @(posedge clk);
         #1;
         n++;
         start = 1'b0;
         if (ready) seen_ready = 1'b1;
         if (!busy) break;
      end
      check("init_idle", 48'(n), 48'(34 * DIV + 1));
      check("init_ready", 48'(seen_ready), 48'd0);
      check("init_frames", 48'(frame_n.size()), 48'd1);
      if (frame_n.size() > 0) begin
         check("init_len", 48'(frame_n.pop_front()), 48'd16);
         b = frame_bits.pop_front();
         check("init_mosi", 48'(b[15:0]), 48'h0140);
      end
      repeat (4 * DIV) begin
         @(posedge clk);
         #1;
         if (busy) late_busy = 1'b1;
      end
      check("init_start_ign", 48'(late_busy), 48'd0);
      frame_n.delete();
      frame_bits.delete();
   endtask
`else
   task automatic post_reset();
      @(posedge clk);
      #1;
      check("idle_busy", 48'(busy), 48'd0);
      check("idle_cs", 48'(spi_cs), 48'd1);
      check("no_frame", 48'(frame_n.size()), 48'd0);
   endtask
`endif

   // mode 0: plain, 1: extra starts while busy, 2: reset mid-shift
   task automatic run_txn(input bit we,
                          input logic [15:0] a,
                          input logic [15:0] d,
                          input int mode);
      int j, cs_j, rdy_j, rdy_cnt, extra;
      logic [15:0] exp_do;
      @(negedge clk);
      start = 1'b1;
      write_enable = we;
      address = a;
      data_in = d;
      @(posedge clk);
      #1;
      start = 1'b0;
      write_enable = ~we;
      address = ~a;
      data_in = ~d;
      check("busy_acc", 48'(busy), 48'd1);
      check("cs_acc", 48'(spi_cs), 48'd0);
      exp_do = we ? last_rd : model_word(a);
      j = 0;
      cs_j = -1;
      rdy_j = -1;
      rdy_cnt = 0;
      while (j < LIMIT) begin
         if (mode == 1 && (j == 4 || j == 99)) begin
            start = 1'b1;
            write_enable = 1'b1;
            address = 16'h00FF;
         end
         if (mode == 2 && j == 42 * DIV) reset = 1'b1;
         @(posedge clk);
         #1;
         j++;
         start = 1'b0;
         if (reset) begin
            check("rst_cs", 48'(spi_cs), 48'd1);
            check("rst_busy", 48'(busy), 48'd0);
            check("rst_sclk", 48'(spi_clk), 48'd0);
            check("rst_do", 48'(spi_do), 48'd0);
            check("rst_dout", 48'(data_out), 48'd0);
            check("abort_frames", 48'(frame_n.size()), 48'd1);
            if (frame_n.size() > 0)
               check("abort_bits", 48'(frame_n.pop_front()), 48'd21);
            frame_n.delete();
            frame_bits.delete();
            last_rd = '0;
            reset = 1'b0;
            post_reset();
            return;
         end
         if (spi_cs && cs_j < 0) cs_j = j;
         if (ready) begin
            rdy_cnt++;
            if (rdy_j < 0) begin
               rdy_j = j;
               check("busy_in_ready", 48'(busy), 48'd1);
               check("dout", 48'(data_out), 48'(exp_do));
            end
         end
         if (!busy) break;
      end
      check("ready_lat", 48'(rdy_j), 48'(98 * DIV));
      check("cs_rise", 48'(cs_j), 48'(97 * DIV));
      check("busy_drop", 48'(j), 48'(98 * DIV + 1));
      check("ready_cnt", 48'(rdy_cnt), 48'd1);
      check("dout_hold", 48'(data_out), 48'(exp_do));
      if (mode == 1) begin
         extra = 0;
         repeat (20) begin
            @(posedge clk);
            #1;
            if (busy || ready) extra++;
         end
         check("no_queue", 48'(extra), 48'd0);
      end
      check_frame(we, a, d);
      if (we) model_mem[int'(a)] = d;
      else last_rd = exp_do;
   endtask

   initial begin
      bit we;
      int pick;
      logic [15:0] a, d;
      sram[2] = 8'hA5;
      sram[3] = 8'h5A;
      model_mem[1] = 16'hA55A;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cs", 48'(spi_cs), 48'd1);
      check("reset_sclk", 48'(spi_clk), 48'd0);
      check("reset_do", 48'(spi_do), 48'd0);
      check("reset_busy", 48'(busy), 48'd0);
      check("reset_ready", 48'(ready), 48'd0);
      check("reset_dout", 48'(data_out), 48'd0);
      @(negedge clk);
      reset = 1'b0;
      post_reset();

      run_txn(1'b1, 16'h1234, 16'hBEEF, 0);
      run_txn(1'b0, 16'h0001, 16'h0000, 0);
      run_txn(1'b0, 16'h1234, 16'h0000, 1);

      for (int i = 0; i < 8; i++) begin
         we = 1'($urandom_range(0, 1));
         pick = $urandom_range(0, 3);
         if (pick == 0) a = 16'h1234;
         else if (pick == 1) a = 16'h0001;
         else a = 16'($urandom_range(0, 7));
         d = 16'($urandom);
         run_txn(we, a, d, 0);
      end

      run_txn(1'b1, 16'h0007, 16'hC3C3, 2);
      run_txn(1'b0, 16'h0003, 16'h0000, 0);
      run_txn(1'b0, 16'h1234, 16'h0000, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
